col_readout_rx: RTL and testbench
=================================

# col_readout_rx

Receive end of the pixel-array serial readout chains. Drives the shift enable for the column chains, deserializes the `Col`-wide A and B bitstreams into per-pixel counter words and delivers them one pixel at a time over a valid/ready stream tagged with row and column. It sits between the digital front-end array's `SerOutA`/`SerOutB` outputs and the chip's output packetizer.

## Interface
- `Row`, 2, pixels per column chain (rows)
- `Col`, 2, number of columns (parallel chains per counter)
- `CntWidth`, 12, bits per pixel counter per chain
- `readClk`  input  1  readout clock; all logic on rising edge
- `resetN`  input  1  asynchronous, active-low reset
- `start`  input  1  one-cycle request to read out the full frame
- `SerOutA`  input  `Col`  serial data from counter-A chains, one bit per column
- `SerOutB`  input  `Col`  serial data from counter-B chains
- `shiftEn`  output  1  array chains advance one bit on each edge where high
- `busy`  output  1  frame readout in progress
- `done`  output  1  one-cycle pulse at frame end
- `pixValid`  output  1  pixel word available
- `pixReady`  input  1  consumer accepts word
- `pixWordA`  output  `CntWidth`  counter-A value
- `pixWordB`  output  `CntWidth`  counter-B value
- `pixRow`  output  `$clog2(Row)` (min 1)  row index of word
- `pixCol`  output  `$clog2(Col)` (min 1)  column index of word

## Operation
- FSM states: IDLE, SHIFT, DRAIN, DONE.
- IDLE: `start`=1 -> SHIFT; rowIdx=0, bitCnt=0.
- SHIFT: `shiftEn`=1. Every edge samples `SerOutA[c]`/`SerOutB[c]` into lane shift registers, MSB first (first sampled bit = bit `CntWidth-1`). bitCnt increments; on the edge with bitCnt==`CntWidth-1`, lanes transfer into the `Col`-entry hold buffer, colIdx=0, state -> DRAIN.
- Chain order: row 0 word emerges first, then row 1, ... row `Row-1`.
- DRAIN: `shiftEn`=0, `pixValid`=1, outputs present hold-buffer entry colIdx, `pixRow`=rowIdx, `pixCol`=colIdx. On `pixValid & pixReady` colIdx++. Handshake on colIdx==`Col-1`: rowIdx==`Row-1` -> DONE, else rowIdx++, bitCnt=0 -> SHIFT.
- DONE: `done`=1 for one cycle -> IDLE.
- `busy`=1 in SHIFT, DRAIN, DONE.
- `start` while busy is ignored; `start` in DONE is ignored.
- Outputs stable while `pixValid & !pixReady` (no change to word, row, col).
- `pixReady` outside DRAIN has no effect.

## Timing
- All outputs decoded from registered state; no combinational input-to-output path.
- `start` at edge N -> `shiftEn` high after edge N; first bit sampled at edge N+1.
- Array shifts on the same edge the bit is sampled (zero shift latency); the bit on `SerOutA/B` before the first shift is the MSB of row 0.
- Per row: `CntWidth` SHIFT cycles + ≥`Col` DRAIN cycles. Frame minimum: `Row*(CntWidth+Col)+1` cycles from start to `done`.
- Reset (any time, including mid-frame): state IDLE, counters 0, `shiftEn`=0, `busy`=0, `done`=0, `pixValid`=0, `pixWordA/B`=0, `pixRow`=0, `pixCol`=0. Array chain state after a mid-frame reset is not recovered; the next frame requires a fresh array load.

## Configuration
- `COL_READOUT_GRAY_DECODE_EN` defined: `pixWordA/B` are Gray-to-binary converted from the received words (conversion on hold-buffer output, combinational, no added latency).
- Not defined: `pixWordA/B` are the raw received bits.

## Structure
- Shared package `readout_pkg`: FSM state enum typedef, `gray2bin` function parameterized by width.
- Sub-module `rx_shift_lane`: one `CntWidth` MSB-first shift register with enable; instantiated `2*Col` times (A and B per column).
- Hold buffer, counters and FSM in the top module.

## Test plan
- Row=2, Col=2, CntWidth=4, raw mode; chains preloaded A={r0c0=0x3,r0c1=0xA,r1c0=0x5,r1c1=0xF}, B=~A; `pixReady`=1 -> words in order (0,0),(0,1),(1,0),(1,1) with matching A/B, `done` at cycle 13 after `start`.
- Backpressure: `pixReady` low for 5 cycles during first DRAIN -> outputs held, `shiftEn`=0 throughout, no word lost or duplicated.
- `start` pulsed in SHIFT and DRAIN -> ignored, exactly 4 words, one `done`.
- `resetN` low mid-SHIFT (bitCnt=2) -> all outputs at reset values asynchronously; following `start` reads a fresh frame correctly.
- Gray mode: chain value 4'b0110 -> `pixWordA`=4'b0100; 4'b1000 -> 4'b1111.
- Row=1, Col=1, CntWidth=1 corner: one word, `done` 3 cycles after `start`.

Source files
------------

// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared FSM state type and Gray decode helper for the column readout receiver
package readout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rxState_t;

    // Only the low `width` bits are decoded; the running XOR walks down from the MSB.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
        logic [31:0] bin;
        logic        acc;
        bin = '0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < width) begin
                acc    = acc ^ gray[i];
                bin[i] = acc;
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/rx_shift_lane.sv
// rtl/rx_shift_lane.sv - one MSB-first serial-to-parallel lane with shift enable
module rx_shift_lane #(
    parameter int Width = 12
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             en,
    input  logic             din,
    output logic [Width-1:0] wordNext
);

    logic [Width-1:0] shiftReg;
    logic [Width-1:0] shifted;

    generate
        if (Width == 1) begin : gSingle
            assign shifted = din;
        end else begin : gMulti
            assign shifted = {shiftReg[Width-2:0], din};
        end
    endgenerate

    // wordNext exposes the word including the bit being sampled this edge.
    assign wordNext = en ? shifted : shiftReg;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shiftReg <= '0;
        end else begin
            shiftReg <= wordNext;
        end
    end

endmodule

// File: rtl/col_readout_rx.sv
// rtl/col_readout_rx.sv - column chain readout receiver; COL_READOUT_GRAY_DECODE_EN selects Gray-to-binary output words
module col_readout_rx
    import readout_pkg::*;
#(
    parameter int Row      = 2,
    parameter int Col      = 2,
    parameter int CntWidth = 12
) (
    input  logic                                   readClk,
    input  logic                                   resetN,
    input  logic                                   start,
    input  logic [Col-1:0]                         SerOutA,
    input  logic [Col-1:0]                         SerOutB,
    output logic                                   shiftEn,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   pixValid,
    input  logic                                   pixReady,
    output logic [CntWidth-1:0]                    pixWordA,
    output logic [CntWidth-1:0]                    pixWordB,
    output logic [((Row > 1) ? $clog2(Row) : 1)-1:0] pixRow,
    output logic [((Col > 1) ? $clog2(Col) : 1)-1:0] pixCol
);

    localparam int RowW = (Row > 1) ? $clog2(Row) : 1;
    localparam int ColW = (Col > 1) ? $clog2(Col) : 1;
    localparam int CntW = (CntWidth > 1) ? $clog2(CntWidth) : 1;

    rxState_t            state, stateNext;
    logic [CntW-1:0]     bitCnt;
    logic [RowW-1:0]     rowIdx;
    logic [ColW-1:0]     colIdx;
    logic [CntWidth-1:0] laneA [Col];
    logic [CntWidth-1:0] laneB [Col];
    logic [CntWidth-1:0] holdA [Col];
    logic [CntWidth-1:0] holdB [Col];
    logic                lastBit, lastCol, lastRow;

    assign lastBit = (bitCnt == CntW'(CntWidth - 1));
    assign lastCol = (colIdx == ColW'(Col - 1));
    assign lastRow = (rowIdx == RowW'(Row - 1));

    genvar c;
    generate
        for (c = 0; c < Col; c++) begin : gLane
            rx_shift_lane #(.Width(CntWidth)) uLaneA (
                .clk(readClk), .resetN(resetN), .en(shiftEn), .din(SerOutA[c]), .wordNext(laneA[c])
            );
            rx_shift_lane #(.Width(CntWidth)) uLaneB (
                .clk(readClk), .resetN(resetN), .en(shiftEn), .din(SerOutB[c]), .wordNext(laneB[c])
            );
        end
    endgenerate

    always_ff @(posedge readClk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = SHIFT;
            SHIFT:   if (lastBit) stateNext = DRAIN;
            DRAIN:   if (pixReady && lastCol) stateNext = lastRow ? DONE : SHIFT;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        shiftEn  = (state == SHIFT);
        pixValid = (state == DRAIN);
        done     = (state == DONE);
        busy     = (state != IDLE);
    end

    // The last shift edge also captures every lane into the hold buffer.
    always_ff @(posedge readClk or negedge resetN) begin
        if (!resetN) begin
            bitCnt <= '0;
            rowIdx <= '0;
            colIdx <= '0;
            for (int i = 0; i < Col; i++) begin
                holdA[i] <= '0;
                holdB[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bitCnt <= '0;
                        rowIdx <= '0;
                        colIdx <= '0;
                    end
                end
                SHIFT: begin
                    bitCnt <= bitCnt + 1'b1;
                    if (lastBit) begin
                        bitCnt <= '0;
                        colIdx <= '0;
                        for (int i = 0; i < Col; i++) begin
                            holdA[i] <= laneA[i];
                            holdB[i] <= laneB[i];
                        end
                    end
                end
                DRAIN: begin
                    if (pixReady) begin
                        if (lastCol) begin
                            colIdx <= '0;
                            if (!lastRow) begin
                                rowIdx <= rowIdx + 1'b1;
                                bitCnt <= '0;
                            end
                        end else begin
                            colIdx <= colIdx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pixRow = rowIdx;
    assign pixCol = colIdx;

`ifdef COL_READOUT_GRAY_DECODE_EN
    assign pixWordA = CntWidth'(gray2bin(32'(holdA[colIdx]), CntWidth));
    assign pixWordB = CntWidth'(gray2bin(32'(holdB[colIdx]), CntWidth));
`else
    assign pixWordA = holdA[colIdx];
    assign pixWordB = holdB[colIdx];
`endif

endmodule

// File: tb/tb_col_readout_rx.sv
// tb/tb_col_readout_rx.sv - scoreboard bench for col_readout_rx with a behavioural chain model
module tb_col_readout_rx;

    localparam int Row = 2;
    localparam int Col = 2;
    localparam int W   = 4;

    logic           readClk = 1'b0;
    logic           resetN  = 1'b0;
    logic           start   = 1'b0;
    logic           pixReady = 1'b0;
    logic [Col-1:0] SerOutA = '0;
    logic [Col-1:0] SerOutB = '0;
    logic           shiftEn, busy, done, pixValid;
    logic [W-1:0]   pixWordA, pixWordB;
    logic [0:0]     pixRow, pixCol;

    logic           sStart = 1'b0;
    logic [0:0]     sA = 1'b0;
    logic [0:0]     sB = 1'b0;
    logic           sShift, sBusy, sDone, sValid;
    logic [0:0]     sWordA, sWordB, sRow, sCol;

    col_readout_rx #(.Row(Row), .Col(Col), .CntWidth(W)) dut (
        .readClk(readClk), .resetN(resetN), .start(start),
        .SerOutA(SerOutA), .SerOutB(SerOutB),
        .shiftEn(shiftEn), .busy(busy), .done(done), .pixValid(pixValid),
        .pixReady(pixReady), .pixWordA(pixWordA), .pixWordB(pixWordB),
        .pixRow(pixRow), .pixCol(pixCol)
    );

    col_readout_rx #(.Row(1), .Col(1), .CntWidth(1)) dutS (
        .readClk(readClk), .resetN(resetN), .start(sStart),
        .SerOutA(sA), .SerOutB(sB),
        .shiftEn(sShift), .busy(sBusy), .done(sDone), .pixValid(sValid),
        .pixReady(1'b1), .pixWordA(sWordA), .pixWordB(sWordB),
        .pixRow(sRow), .pixCol(sCol)
    );

    always #5 readClk = ~readClk;

    int passCnt  = 0;
    int checkCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        int         row;
        int         col;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pix_t;

    pix_t         expQ[$];
    pix_t         e;
    logic [W-1:0] frameA[Row][Col];
    logic [W-1:0] frameB[Row][Col];
    logic         chainA[Col][$];
    logic         chainB[Col][$];
    int           ptr = 0;

    function automatic logic [W-1:0] decode(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
`ifdef COL_READOUT_GRAY_DECODE_EN
        for (int s = 1; s < W; s++) r = r ^ (v >> s);
`endif
        return r;
    endfunction

    task automatic loadFrame();
        for (int c = 0; c < Col; c++) begin
            chainA[c].delete();
            chainB[c].delete();
        end
        for (int r = 0; r < Row; r++)
            for (int c = 0; c < Col; c++)
                expQ.push_back('{row: r, col: c, a: decode(frameA[r][c]), b: decode(frameB[r][c])});
        for (int c = 0; c < Col; c++)
            for (int r = 0; r < Row; r++)
                for (int b = W - 1; b >= 0; b--) begin
                    chainA[c].push_back(frameA[r][c][b]);
                    chainB[c].push_back(frameB[r][c][b]);
                end
        ptr = 0;
    endtask

    task automatic randomFrame();
        for (int r = 0; r < Row; r++)
            for (int c = 0; c < Col; c++) begin
                frameA[r][c] = W'($urandom);
                frameB[r][c] = W'($urandom);
            end
    endtask

    // Array chain model: the bit in front of the chain advances on every enabled edge.
    always @(posedge readClk) if (shiftEn) ptr++;
    always @(negedge readClk) begin
        for (int c = 0; c < Col; c++) begin
            SerOutA[c] = (ptr < chainA[c].size()) ? chainA[c][ptr] : 1'b0;
            SerOutB[c] = (ptr < chainB[c].size()) ? chainB[c][ptr] : 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge readClk) cyc++;

    int readyMode = 0;
    int lowLeft   = 0;
    always @(posedge readClk) begin
        #1;
        case (readyMode)
            0:       pixReady = 1'b1;
            1:       pixReady = 1'($urandom_range(0, 1));
            default: begin
                if (pixValid && lowLeft > 0) begin
                    pixReady = 1'b0;
                    lowLeft--;
                end else begin
                    pixReady = 1'b1;
                end
            end
        endcase
    end

    int          doneCnt = 0;
    int          doneCyc = 0;
    logic        heldValid = 1'b0;
    logic [63:0] heldSnap;
    always @(negedge readClk) begin
        if (done) begin
            doneCnt++;
            doneCyc = cyc;
        end
        if (heldValid)
            check("hold_stable", {pixRow, pixCol, pixWordA, pixWordB, shiftEn}, heldSnap);
        if (pixValid && !pixReady) begin
            heldValid = 1'b1;
            heldSnap  = {pixRow, pixCol, pixWordA, pixWordB, 1'b0};
        end else begin
            heldValid = 1'b0;
        end
        if (pixValid && pixReady) begin
            if (expQ.size() == 0) begin
                checkCnt++;
                $display("FAIL extra_word: got row %0d col %0d a %0h b %0h, expected none", pixRow, pixCol, pixWordA, pixWordB);
            end else begin
                e = expQ.pop_front();
                check("pixel_word", {pixRow, pixCol, pixWordA, pixWordB},
                      {1'(e.row), 1'(e.col), e.a, e.b});
            end
        end
    end

    int   sWords = 0;
    int   sDoneCnt = 0;
    int   sDoneCyc = 0;
    logic sExpA = 1'b0;
    always @(negedge readClk) begin
        if (sValid) begin
            check("corner_word", {sRow, sCol, sWordA, sWordB}, {2'b00, sExpA, ~sExpA});
            sWords++;
        end
        if (sDone) begin
            sDoneCnt++;
            sDoneCyc = cyc;
        end
    end

    task automatic runFrame(input bit inject, input int expLat);
        int startCyc, d0, n;
        loadFrame();
        @(posedge readClk);
        #2;
        start    = 1'b1;
        startCyc = cyc;
        d0       = doneCnt;
        for (n = 0; n < 200 && doneCnt == d0; n++) begin
            @(posedge readClk);
            #2;
            start = inject && busy && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        repeat (4) @(posedge readClk);
        #2;
        check("done_once", 64'(doneCnt - d0), 64'd1);
        check("queue_drained", 64'(expQ.size()), 64'd0);
        if (expLat > 0) check("frame_latency", 64'(doneCyc - startCyc), 64'(expLat));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sc;
        resetN = 1'b0;
        repeat (3) @(posedge readClk);
        #2;
        check("reset_state", {shiftEn, busy, done, pixValid, pixWordA, pixWordB, pixRow, pixCol}, 64'd0);
        check("reset_state_corner", {sShift, sBusy, sDone, sValid, sWordA, sWordB, sRow, sCol}, 64'd0);
        resetN = 1'b1;

        // Reference frame: B is the bitwise complement of A.
        frameA[0][0] = 4'h3; frameA[0][1] = 4'hA; frameA[1][0] = 4'h5; frameA[1][1] = 4'hF;
        for (int r = 0; r < Row; r++)
            for (int c = 0; c < Col; c++) frameB[r][c] = ~frameA[r][c];
        readyMode = 0;
        runFrame(1'b0, Row * (W + Col) + 1);

        randomFrame();
        frameA[0][0] = 4'b0110;
        frameA[0][1] = 4'b1000;
        readyMode = 2;
        lowLeft   = 5;
        runFrame(1'b0, 0);
        check("backpressure_consumed", 64'(lowLeft), 64'd0);

        randomFrame();
        readyMode = 0;
        runFrame(1'b1, 0);

        randomFrame();
        loadFrame();
        @(posedge readClk);
        #2;
        start = 1'b1;
        @(posedge readClk);
        #2;
        start = 1'b0;
        repeat (2) @(posedge readClk);
        #3;
        check("pre_reset_busy", {busy, shiftEn}, 2'b11);
        resetN = 1'b0;
        #1;
        check("async_reset", {shiftEn, busy, done, pixValid, pixWordA, pixWordB, pixRow, pixCol}, 64'd0);
        expQ.delete();
        repeat (2) @(posedge readClk);
        @(negedge readClk);
        resetN = 1'b1;

        randomFrame();
        runFrame(1'b0, Row * (W + Col) + 1);

        readyMode = 1;
        for (int f = 0; f < 6; f++) begin
            randomFrame();
            runFrame(f[0], 0);
        end
        readyMode = 0;

        sExpA = 1'($urandom);
        sA    = sExpA;
        sB    = ~sExpA;
        @(posedge readClk);
        #2;
        sStart = 1'b1;
        sc     = cyc;
        @(posedge readClk);
        #2;
        sStart = 1'b0;
        repeat (8) @(posedge readClk);
        #2;
        check("corner_word_count", 64'(sWords), 64'd1);
        check("corner_done_count", 64'(sDoneCnt), 64'd1);
        check("corner_latency", 64'(sDoneCyc - sc), 64'd3);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
